// File: rtl/ball_regfile_avalon.sv
// Avalon-MM ball register file: shadow/live banks with a frame-synchronous commit,
// plus a two-stage per-pixel circle hit tester driving is_ball/ballID.
module ball_regfile_avalon #(
    parameter int unsigned NBALLS = 4,
    parameter int unsigned CW     = 10,
    parameter int unsigned RW     = 6
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        chipselect,
    input  logic                        read,
    input  logic                        write,
    input  logic [2:0]                  address,
    input  logic [3:0]                  byteenable,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    input  logic                        VGA_VS,
    input  logic [CW-1:0]               DrawX,
    input  logic [CW-1:0]               DrawY,
    output logic                        is_ball,
    output logic [$clog2(NBALLS)-1:0]   ballID
);
    localparam int unsigned IDW = $clog2(NBALLS);
    localparam int unsigned R2W = 2 * RW;
    localparam int unsigned SW  = 2 * CW + 1;
    localparam logic [31:0] WORD_MASK = 32'h83FF_FFFF;

    logic [31:0]    shadow_q [NBALLS];
    logic [31:0]    shadow_d [NBALLS];
    logic [31:0]    live_q   [NBALLS];
    logic [31:0]    live_d   [NBALLS];
    logic           pending_q, pending_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [IDW-1:0] sel_q, sel_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           vs_q;

    logic [CW-1:0]  dx_q [NBALLS];
    logic [CW-1:0]  dx_d [NBALLS];
    logic [CW-1:0]  dy_q [NBALLS];
    logic [CW-1:0]  dy_d [NBALLS];
    logic [R2W-1:0] r2_q [NBALLS];
    logic [R2W-1:0] r2_d [NBALLS];
    logic [NBALLS-1:0] en_q, en_d;
    logic           is_ball_q, is_ball_d;
    logic [IDW-1:0] ball_id_q, ball_id_d;

    logic           wr_c, rd_c, vs_fall_c, swap_c;
    logic [31:0]    wmask_c;
    logic signed [CW:0] sdx_c [NBALLS];
    logic signed [CW:0] sdy_c [NBALLS];
    logic [CW:0]    adx_c [NBALLS];
    logic [CW:0]    ady_c [NBALLS];
    logic [RW-1:0]  rad_c [NBALLS];
    logic [SW-1:0]  dist_c [NBALLS];
    logic [NBALLS-1:0] hit_c;

    assign wr_c      = chipselect & write;
    assign rd_c      = chipselect & read;
    assign vs_fall_c = vs_q & ~VGA_VS;
    assign swap_c    = vs_fall_c & pending_q;
    assign wmask_c   = {{8{byteenable[3]}}, {8{byteenable[2]}},
                        {8{byteenable[1]}}, {8{byteenable[0]}}};

    // Register file, commit handshake and read mux; swap sees pre-write shadow values
    always_comb begin
        for (int i = 0; i < NBALLS; i++) begin
            shadow_d[i] = shadow_q[i];
            live_d[i]   = live_q[i];
            if (wr_c && address == 3'(i))
                shadow_d[i] = ((shadow_q[i] & ~wmask_c) | (writedata & wmask_c)) & WORD_MASK;
            if (swap_c)
                live_d[i] = shadow_q[i];
        end
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        sel_d       = sel_q;
        rdata_d     = rdata_q;
        if (swap_c)
            pending_d = 1'b0;
        if (vs_fall_c)
            frame_cnt_d = frame_cnt_q + 16'd1;
        if (wr_c && address == 3'd4 && byteenable[0] && writedata[0])
            pending_d = 1'b1;
        if (wr_c && address == 3'd5 && byteenable[0])
            sel_d = writedata[IDW-1:0];
        if (rd_c) begin
            case (address)
                3'd0, 3'd1, 3'd2, 3'd3: rdata_d = shadow_q[address[IDW-1:0]];
                3'd4:    rdata_d = {frame_cnt_q, 15'd0, pending_q};
                3'd5:    rdata_d = {(32-IDW)'(0), sel_q};
                3'd6:    rdata_d = live_q[sel_q];
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // Hit stage 1: absolute deltas and squared radius from the live bank
    always_comb begin
        for (int i = 0; i < NBALLS; i++) begin
            sdx_c[i] = $signed({1'b0, DrawX}) - $signed({1'b0, live_q[i][CW-1:0]});
            sdy_c[i] = $signed({1'b0, DrawY}) - $signed({1'b0, live_q[i][2*CW-1:CW]});
            adx_c[i] = sdx_c[i][CW] ? (CW+1)'(-sdx_c[i]) : (CW+1)'(sdx_c[i]);
            ady_c[i] = sdy_c[i][CW] ? (CW+1)'(-sdy_c[i]) : (CW+1)'(sdy_c[i]);
            dx_d[i]  = adx_c[i][CW-1:0];
            dy_d[i]  = ady_c[i][CW-1:0];
            rad_c[i] = live_q[i][2*CW+RW-1:2*CW];
            r2_d[i]  = R2W'(rad_c[i]) * R2W'(rad_c[i]);
            en_d[i]  = live_q[i][31];
        end
    end

    // Hit stage 2: full-width distance compare, lowest index wins
    always_comb begin
        is_ball_d = 1'b0;
        ball_id_d = '0;
        for (int i = 0; i < NBALLS; i++) begin
            dist_c[i] = SW'(dx_q[i]) * SW'(dx_q[i]) + SW'(dy_q[i]) * SW'(dy_q[i]);
            hit_c[i]  = en_q[i] && (dist_c[i] <= SW'(r2_q[i]));
        end
        for (int i = NBALLS - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                is_ball_d = 1'b1;
                ball_id_d = IDW'(i);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NBALLS; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
                dx_q[i]     <= '0;
                dy_q[i]     <= '0;
                r2_q[i]     <= '0;
            end
            en_q        <= '0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            sel_q       <= '0;
            rdata_q     <= '0;
            vs_q        <= 1'b1;
            is_ball_q   <= 1'b0;
            ball_id_q   <= '0;
        end else begin
            for (int i = 0; i < NBALLS; i++) begin
                shadow_q[i] <= shadow_d[i];
                live_q[i]   <= live_d[i];
                dx_q[i]     <= dx_d[i];
                dy_q[i]     <= dy_d[i];
                r2_q[i]     <= r2_d[i];
            end
            en_q        <= en_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            sel_q       <= sel_d;
            rdata_q     <= rdata_d;
            vs_q        <= VGA_VS;
            is_ball_q   <= is_ball_d;
            ball_id_q   <= ball_id_d;
        end
    end

    assign readdata = rdata_q;
    assign is_ball  = is_ball_q;
    assign ballID   = ball_id_q;

endmodule

// File: tb/tb_ball_regfile_avalon.sv
// Bench for ball_regfile_avalon: register vector table, directed frame/commit/hit
// sequences, and randomized traffic against a behavioural model.
module tb_ball_regfile_avalon;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        chipselect, read, write;
    logic [2:0]  address;
    logic [3:0]  byteenable;
    logic [31:0] writedata, readdata;
    logic        VGA_VS;
    logic [9:0]  DrawX, DrawY;
    logic        is_ball;
    logic [1:0]  ballID;

    always #5 Clk = ~Clk;

    ball_regfile_avalon dut (
        .Clk(Clk), .Reset_n(Reset_n), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .byteenable(byteenable), .writedata(writedata),
        .readdata(readdata), .VGA_VS(VGA_VS), .DrawX(DrawX), .DrawY(DrawY),
        .is_ball(is_ball), .ballID(ballID)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] sh_m [4];
    logic [31:0] lv_m [4];
    logic        pend_m;
    logic [15:0] fc_m;
    logic [1:0]  sel_m;
    logic        vsq_m;
    logic [31:0] rd_m;

    typedef struct {
        logic [2:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_m[i] = 32'd0;
            lv_m[i] = 32'd0;
        end
        pend_m = 1'b0; fc_m = 16'd0; sel_m = 2'd0; vsq_m = 1'b1; rd_m = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return sh_m[a[1:0]];
            3'd4:    return {fc_m, 15'd0, pend_m};
            3'd5:    return {30'd0, sel_m};
            3'd6:    return lv_m[sel_m];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void hit_model(input int x, input int y, output logic h, output logic [1:0] id);
        h = 1'b0; id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            int bx = int'(lv_m[i][9:0]);
            int by = int'(lv_m[i][19:10]);
            int br = int'(lv_m[i][25:20]);
            if (lv_m[i][31] && ((x - bx) * (x - bx) + (y - by) * (y - by) <= br * br)) begin
                h = 1'b1; id = 2'(i);
            end
        end
    endfunction

    // One bus/frame clock cycle; model advances with the same inputs
    task automatic step(input logic rd, input logic wr, input logic [2:0] a, input logic [3:0] be,
                        input logic [31:0] d, input logic vs, output logic [31:0] exp);
        logic [31:0] m;
        chipselect = rd | wr; read = rd; write = wr;
        address = a; byteenable = be; writedata = d; VGA_VS = vs;
        if (rd) rd_m = model_read(a);
        exp = rd_m;
        @(posedge Clk); #1;
        if (vsq_m && !vs) begin
            fc_m = fc_m + 16'd1;
            if (pend_m) begin
                for (int i = 0; i < 4; i++) lv_m[i] = sh_m[i];
                pend_m = 1'b0;
            end
        end
        vsq_m = vs;
        if (wr) begin
            m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            if (a < 3'd4) sh_m[a[1:0]] = ((sh_m[a[1:0]] & ~m) | (d & m)) & 32'h83FF_FFFF;
            if (a == 3'd4 && be[0] && d[0]) pend_m = 1'b1;
            if (a == 3'd5 && be[0]) sel_m = d[1:0];
        end
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        VGA_VS = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] e;
        step(1'b0, 1'b1, a, be, d, 1'b1, e);
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] e;
        step(1'b1, 1'b0, a, 4'h0, 32'd0, 1'b1, e);
        check(name, readdata, exp);
    endtask

    task automatic idle(input logic vs);
        logic [31:0] e;
        step(1'b0, 1'b0, 3'd0, 4'h0, 32'd0, vs, e);
    endtask

    task automatic vs_pulse();
        idle(1'b0);
        idle(1'b1);
    endtask

    task automatic hit_check(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic exp_h, input logic [1:0] exp_id);
        DrawX = x; DrawY = y;
        idle(1'b1);
        idle(1'b1);
        check({name, "_is"}, {31'd0, is_ball}, {31'd0, exp_h});
        check({name, "_id"}, {30'd0, ballID}, {30'd0, exp_id});
    endtask

    initial begin
        logic [31:0] e;
        logic        h;
        logic [1:0]  id;
        int          k, px, py, rr;

        vecs[0] = '{3'd0, 4'hF, 32'h80A1_90C8, 3'd0, 32'h80A1_90C8};
        vecs[1] = '{3'd1, 4'hF, 32'hFFFF_FFFF, 3'd1, 32'h83FF_FFFF};
        vecs[2] = '{3'd3, 4'h1, 32'hFFFF_FFFF, 3'd3, 32'h0000_00FF};
        vecs[3] = '{3'd3, 4'h2, 32'h0000_AB00, 3'd3, 32'h0000_ABFF};
        vecs[4] = '{3'd7, 4'hF, 32'hFFFF_FFFF, 3'd7, 32'h0000_0000};
        vecs[5] = '{3'd6, 4'hF, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000};
        vecs[6] = '{3'd5, 4'hF, 32'h0000_0002, 3'd6, 32'h0000_0000};
        vecs[7] = '{3'd4, 4'hF, 32'h0000_0000, 3'd4, 32'h0000_0000};
        vecs[8] = '{3'd4, 4'hF, 32'h0000_0001, 3'd4, 32'h0000_0001};

        chipselect = 0; read = 0; write = 0; address = 0; byteenable = 0; writedata = 0;
        VGA_VS = 1; DrawX = 0; DrawY = 0; Reset_n = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1;
        @(negedge Clk);

        check("rst_readdata", readdata, 32'd0);
        check("rst_is_ball", {31'd0, is_ball}, 32'd0);
        check("rst_ballid", {30'd0, ballID}, 32'd0);
        rd_check("rst_ctrl", 3'd4, 32'd0);

        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].wa, vecs[i].be, vecs[i].wd);
            rd_check($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
        end

        // Commit then frame edge; hit boundary and 2-cycle latency
        vs_pulse();
        rd_check("t1_ctrl", 3'd4, 32'h0001_0000);
        hit_check("t1_miss", 10'd211, 10'd100, 1'b0, 2'd0);
        DrawX = 10'd205; DrawY = 10'd104;
        idle(1'b1);
        check("t1_lat1", {31'd0, is_ball}, 32'd0);
        idle(1'b1);
        check("t1_hit_is", {31'd0, is_ball}, 32'd1);
        check("t1_hit_id", {30'd0, ballID}, 32'd0);
        hit_check("t1_edge", 10'd210, 10'd100, 1'b1, 2'd0);

        // Writes after commit are included; write on the falling cycle is not
        wr(3'd4, 4'hF, 32'd1);
        wr(3'd0, 4'hF, 32'h80A1_912C);
        step(1'b0, 1'b1, 3'd0, 4'hF, 32'h80A1_9190, 1'b0, e);
        idle(1'b1);
        wr(3'd5, 4'hF, 32'd0);
        rd_check("t2_live0", 3'd6, 32'h80A1_912C);
        rd_check("t2_shadow0", 3'd0, 32'h80A1_9190);
        rd_check("t2_ctrl", 3'd4, 32'h0002_0000);

        // Overlapping balls: lowest enabled index wins
        wr(3'd1, 4'hF, 32'h8050_C832);
        wr(3'd2, 4'hF, 32'h80A0_C832);
        wr(3'd4, 4'hF, 32'd1);
        vs_pulse();
        hit_check("t3_overlap", 10'd50, 10'd50, 1'b1, 2'd1);
        hit_check("t3_ball2only", 10'd58, 10'd50, 1'b1, 2'd2);
        wr(3'd1, 4'hF, 32'h0050_C832);
        wr(3'd4, 4'hF, 32'd1);
        vs_pulse();
        hit_check("t3_en_cleared", 10'd50, 10'd50, 1'b1, 2'd2);

        // Commit write coinciding with the frame edge keeps pending set
        wr(3'd0, 4'hF, 32'h1234_5678);
        wr(3'd4, 4'hF, 32'd1);
        step(1'b0, 1'b1, 3'd4, 4'hF, 32'd1, 1'b0, e);
        idle(1'b1);
        rd_check("t5_ctrl_pend", 3'd4, 32'h0005_0001);
        rd_check("t5_live0", 3'd6, 32'h0234_5678);
        vs_pulse();
        rd_check("t5_ctrl_clear", 3'd4, 32'h0006_0000);
        idle(1'b1);
        check("t4_rdata_hold", readdata, 32'h0006_0000);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            k = $urandom_range(0, 9);
            if (k < 4) begin
                step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom), $urandom,
                     1'($urandom_range(0, 3) != 0), e);
            end else if (k < 6) begin
                step(1'b0, 1'b1, 3'd4, 4'hF, 32'($urandom_range(0, 1)), 1'b1, e);
            end else if (k < 8) begin
                address = 3'($urandom_range(0, 7));
                if (address == 3'd5) address = 3'd6;
                step(1'b1, 1'b0, address, 4'h0, 32'd0, 1'($urandom_range(0, 1)), e);
                check("rnd_read", readdata, e);
            end else begin
                k  = $urandom_range(0, 3);
                rr = int'(lv_m[k][25:20]) + 2;
                px = int'(lv_m[k][9:0]) + $urandom_range(0, 2 * rr) - rr;
                py = int'(lv_m[k][19:10]) + $urandom_range(0, 2 * rr) - rr;
                if (px < 0) px = 0;
                if (px > 1023) px = 1023;
                if (py < 0) py = 0;
                if (py > 1023) py = 1023;
                hit_model(px, py, h, id);
                hit_check("rnd_hit", 10'(px), 10'(py), h, id);
            end
        end

        // Frame counter sweep
        for (int i = 0; i < 1000; i++) vs_pulse();
        step(1'b1, 1'b0, 3'd4, 4'h0, 32'd0, 1'b1, e);
        check("fc_sweep", readdata, e);

        // Asynchronous mid-frame reset
        wr(3'd0, 4'hF, 32'h80A1_90C8);
        wr(3'd4, 4'hF, 32'd1);
        vs_pulse();
        wr(3'd5, 4'hF, 32'd0);
        hit_check("pre_rst", 10'd205, 10'd104, 1'b1, 2'd0);
        rd_check("pre_rst_live0", 3'd6, 32'h80A1_90C8);
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("rst_async_rdata", readdata, 32'd0);
        check("rst_async_is", {31'd0, is_ball}, 32'd0);
        check("rst_async_id", {30'd0, ballID}, 32'd0);
        model_reset();
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        rd_check("post_rst_ctrl", 3'd4, 32'd0);
        rd_check("post_rst_live0", 3'd6, 32'd0);
        hit_check("post_rst_hit", 10'd205, 10'd104, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
